knn_batch_ctrl: RTL and testbench

Parametrised next-generation KNN sequencer. It classifies a batch of up to MAX_QUERIES test vectors back-to-back, and evaluates LANES training samples per distance round. It adds runtime metric select (L1/L2), configuration checking, per-wait timeout and abort. It sits between the feature/label/test memories and the distance, k-best and vote datapath blocks.

---
 rtl/knn_batch_ctrl_if.sv | 68 ++++++
 rtl/knn_batch_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_knn_batch_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/knn_batch_ctrl_if.sv
// knn_batch_ctrl_if: host/config inputs, done strobes and memory/datapath controls of the KNN batch sequencer
// master: the sequencer (drives read enables, indices, pulses, status)
// slave : host plus test/sample/label memories and distance/k-best/vote blocks
interface knn_batch_ctrl_if #(
    parameter int NUM_FEATURES = 16,
    parameter int MAX_K        = 15,
    parameter int LANES        = 4,
    parameter int MAX_QUERIES  = 8,
    parameter int ADDR_WIDTH   = 12
);
    localparam int K_W  = $clog2(MAX_K + 1);
    localparam int NF_W = $clog2(NUM_FEATURES + 1);
    localparam int NQ_W = $clog2(MAX_QUERIES + 1);
    localparam int TA_W = $clog2(MAX_QUERIES * NUM_FEATURES);
    localparam int FI_W = $clog2(NUM_FEATURES);
    localparam int LR_W = $clog2(MAX_K);
    localparam int QI_W = $clog2(MAX_QUERIES);

    // host side
    logic                  start;
    logic                  abort;
    logic [K_W-1:0]        cfg_k;
    logic [ADDR_WIDTH-1:0] cfg_num_samples;
    logic [NF_W-1:0]       cfg_num_features;
    logic [NQ_W-1:0]       cfg_num_queries;
    logic                  cfg_metric;
    // datapath completion strobes
    logic                  dist_done;
    logic                  sort_done;
    logic                  vote_done;
    // memory and datapath controls
    logic                  test_ren;
    logic [TA_W-1:0]       test_raddr;
    logic                  sample_ren;
    logic [ADDR_WIDTH-1:0] sample_group;
    logic [FI_W-1:0]       feature_idx;
    logic [LANES-1:0]      lane_valid;
    logic                  dist_start;
    logic                  dist_metric;
    logic                  sort_clear;
    logic                  sort_start;
    logic                  label_ren;
    logic [LR_W-1:0]       label_raddr;
    logic                  vote_start;
    // status
    logic [QI_W-1:0]       query_idx;
    logic                  query_done;
    logic                  batch_done;
    logic                  busy;
    logic                  error;
    logic [1:0]            err_code;

    modport master (
        input  start, abort, cfg_k, cfg_num_samples, cfg_num_features, cfg_num_queries, cfg_metric,
               dist_done, sort_done, vote_done,
        output test_ren, test_raddr, sample_ren, sample_group, feature_idx, lane_valid,
               dist_start, dist_metric, sort_clear, sort_start, label_ren, label_raddr, vote_start,
               query_idx, query_done, batch_done, busy, error, err_code
    );

    modport slave (
        output start, abort, cfg_k, cfg_num_samples, cfg_num_features, cfg_num_queries, cfg_metric,
               dist_done, sort_done, vote_done,
        input  test_ren, test_raddr, sample_ren, sample_group, feature_idx, lane_valid,
               dist_start, dist_metric, sort_clear, sort_start, label_ren, label_raddr, vote_start,
               query_idx, query_done, batch_done, busy, error, err_code
    );
endinterface

// File: rtl/knn_batch_ctrl.sv
// knn_batch_ctrl: sequences a batch of KNN queries (test load, lane-group distance rounds, sort, labels, vote).
// Latency: 1 CHECK cycle, then per query F + groups*(F + dist wait) + sort wait + K + vote wait + 1; DONE 1 cycle.
// Backpressure: none on outputs; waits on dist/sort/vote done strobes, each bounded by TIMEOUT cycles.
// Ports: clk, rst (sync, active high); bus = knn_batch_ctrl_if.master (config/start/abort in, controls/status out).
module knn_batch_ctrl #(
    parameter int NUM_SAMPLES  = 256,
    parameter int NUM_FEATURES = 16,
    parameter int MAX_K        = 15,
    parameter int LANES        = 4,
    parameter int MAX_QUERIES  = 8,
    parameter int ADDR_WIDTH   = 12,
    parameter int TIMEOUT      = 1023
) (
    input  logic             clk,
    input  logic             rst,
    knn_batch_ctrl_if.master bus
);
    localparam int K_W   = $clog2(MAX_K + 1);
    localparam int NF_W  = $clog2(NUM_FEATURES + 1);
    localparam int NQ_W  = $clog2(MAX_QUERIES + 1);
    localparam int TA_W  = $clog2(MAX_QUERIES * NUM_FEATURES);
    localparam int FI_W  = $clog2(NUM_FEATURES);
    localparam int LR_W  = $clog2(MAX_K);
    localparam int QI_W  = $clog2(MAX_QUERIES);
    // one counter serves feature and label sequencing, so it must hold both F and K
    localparam int CNT_W = (NF_W > K_W) ? NF_W : K_W;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_LOAD_TEST, S_FETCH, S_DIST, S_SORT,
        S_LABELS, S_VOTE, S_NEXT_Q, S_DONE, S_ERR
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [K_W-1:0]        r_k;
    logic [ADDR_WIDTH-1:0] r_ns;
    logic [NF_W-1:0]       r_nf;
    logic [NQ_W-1:0]       r_nq;
    logic                  r_metric;
    logic [CNT_W-1:0]      r_cnt;
    logic [TMO_W-1:0]      r_tmo;
    logic [ADDR_WIDTH-1:0] r_group;
    logic [QI_W-1:0]       r_query;
    logic                  r_error;
    logic [1:0]            r_err_code;

    logic                  w_bad_cfg;
    logic                  w_cnt_last_f;
    logic                  w_cnt_last_k;
    logic                  w_group_last;
    logic                  w_query_last;
    logic                  w_tmo_term;
    logic [31:0]           w_ngroups;
    logic [31:0]           w_base;
    logic [LANES-1:0]      w_lane_valid;

    always_comb begin
        w_bad_cfg = (r_k == '0) || (32'(r_k) > 32'(MAX_K)) || (32'(r_k) > 32'(r_ns)) ||
                    (r_ns == '0) || (32'(r_ns) > 32'(NUM_SAMPLES)) ||
                    (r_nf == '0) || (32'(r_nf) > 32'(NUM_FEATURES)) ||
                    (r_nq == '0) || (32'(r_nq) > 32'(MAX_QUERIES));
        w_cnt_last_f = (32'(r_cnt) == 32'(r_nf) - 32'd1);
        w_cnt_last_k = (32'(r_cnt) == 32'(r_k) - 32'd1);
        w_ngroups    = (32'(r_ns) + 32'(LANES) - 32'd1) / 32'(LANES);
        w_group_last = (32'(r_group) == w_ngroups - 32'd1);
        w_query_last = (32'(r_query) == 32'(r_nq) - 32'd1);
        // r_tmo counts wait cycles already spent, so the wait state lasts at most TIMEOUT cycles
        w_tmo_term   = (32'(r_tmo) == 32'(TIMEOUT) - 32'd1);
        w_base       = 32'(r_group) * 32'(LANES);
        w_lane_valid = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_valid[i] = (w_base + 32'(i)) < 32'(r_ns);
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state; abort outranks every done strobe and the timeout, and a done outranks the timeout
    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_ERR: if (bus.start) w_state_nxt = S_CHECK;
                S_CHECK:       w_state_nxt = w_bad_cfg ? S_ERR : S_LOAD_TEST;
                S_LOAD_TEST:   if (w_cnt_last_f) w_state_nxt = S_FETCH;
                S_FETCH:       if (w_cnt_last_f) w_state_nxt = S_DIST;
                S_DIST: begin
                    if (bus.dist_done)   w_state_nxt = w_group_last ? S_SORT : S_FETCH;
                    else if (w_tmo_term) w_state_nxt = S_ERR;
                end
                S_SORT: begin
                    if (bus.sort_done)   w_state_nxt = S_LABELS;
                    else if (w_tmo_term) w_state_nxt = S_ERR;
                end
                S_LABELS:      if (w_cnt_last_k) w_state_nxt = S_VOTE;
                S_VOTE: begin
                    if (bus.vote_done)   w_state_nxt = S_NEXT_Q;
                    else if (w_tmo_term) w_state_nxt = S_ERR;
                end
                S_NEXT_Q:      w_state_nxt = w_query_last ? S_DONE : S_LOAD_TEST;
                S_DONE:        w_state_nxt = S_IDLE;
                default:       w_state_nxt = S_IDLE;
            endcase
        end
    end

    // counters, latched configuration and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k        <= '0;
            r_ns       <= '0;
            r_nf       <= '0;
            r_nq       <= '0;
            r_metric   <= 1'b0;
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_group    <= '0;
            r_query    <= '0;
            r_error    <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            // every state change restarts both the sequencing and the timeout counters
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
                r_tmo <= '0;
            end else begin
                if (r_state == S_LOAD_TEST || r_state == S_FETCH || r_state == S_LABELS)
                    r_cnt <= r_cnt + CNT_W'(1);
                if (r_state == S_DIST || r_state == S_SORT || r_state == S_VOTE)
                    r_tmo <= r_tmo + TMO_W'(1);
            end
            // CHECK is only reachable by an accepted start
            if (w_state_nxt == S_CHECK) begin
                r_k        <= bus.cfg_k;
                r_ns       <= bus.cfg_num_samples;
                r_nf       <= bus.cfg_num_features;
                r_nq       <= bus.cfg_num_queries;
                r_metric   <= bus.cfg_metric;
                r_error    <= 1'b0;
                r_err_code <= 2'b00;
                r_query    <= '0;
                r_group    <= '0;
            end
            if (w_state_nxt == S_ERR && r_state != S_ERR) begin
                r_error    <= 1'b1;
                r_err_code <= (r_state == S_CHECK) ? 2'b01 : 2'b10;
            end
            if (r_state == S_LOAD_TEST && w_state_nxt == S_FETCH) r_group <= '0;
            if (r_state == S_DIST && w_state_nxt == S_FETCH)      r_group <= r_group + ADDR_WIDTH'(1);
            if (r_state == S_NEXT_Q && w_state_nxt == S_LOAD_TEST) r_query <= r_query + QI_W'(1);
        end
    end

    // outputs; entry pulses key off the freshly zeroed counters
    always_comb begin
        bus.test_ren     = (r_state == S_LOAD_TEST);
        bus.test_raddr   = (r_state == S_LOAD_TEST) ?
                           TA_W'(32'(r_query) * 32'(NUM_FEATURES) + 32'(r_cnt)) : '0;
        bus.sample_ren   = (r_state == S_FETCH);
        bus.sample_group = r_group;
        bus.feature_idx  = (r_state == S_FETCH) ? FI_W'(r_cnt) : '0;
        bus.lane_valid   = (r_state == S_FETCH || r_state == S_DIST) ? w_lane_valid : '0;
        bus.dist_start   = (r_state == S_DIST) && (r_tmo == '0);
        bus.dist_metric  = r_metric;
        bus.sort_clear   = (r_state == S_LOAD_TEST) && (r_cnt == '0);
        bus.sort_start   = (r_state == S_SORT) && (r_tmo == '0);
        bus.label_ren    = (r_state == S_LABELS);
        bus.label_raddr  = (r_state == S_LABELS) ? LR_W'(r_cnt) : '0;
        bus.vote_start   = (r_state == S_VOTE) && (r_tmo == '0);
        bus.query_idx    = r_query;
        bus.query_done   = (r_state == S_NEXT_Q);
        bus.batch_done   = (r_state == S_DONE);
        bus.busy         = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
        bus.error        = r_error;
        bus.err_code     = r_err_code;
    end
endmodule

// File: tb/tb_knn_batch_ctrl.sv
// tb_knn_batch_ctrl: randomized and directed batches for knn_batch_ctrl against an event-sequence reference model.
// Latency: n/a (bench). Backpressure: done strobes returned after random delays; every wait is cycle-bounded.
module tb_knn_batch_ctrl;
    localparam int NUM_SAMPLES  = 256;
    localparam int NUM_FEATURES = 16;
    localparam int MAX_K        = 15;
    localparam int LANES        = 4;
    localparam int MAX_QUERIES  = 8;
    localparam int ADDR_WIDTH   = 12;
    localparam int TIMEOUT      = 1023;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    knn_batch_ctrl_if #(
        .NUM_FEATURES(NUM_FEATURES), .MAX_K(MAX_K), .LANES(LANES),
        .MAX_QUERIES(MAX_QUERIES), .ADDR_WIDTH(ADDR_WIDTH)
    ) bus ();

    knn_batch_ctrl #(
        .NUM_SAMPLES(NUM_SAMPLES), .NUM_FEATURES(NUM_FEATURES), .MAX_K(MAX_K), .LANES(LANES),
        .MAX_QUERIES(MAX_QUERIES), .ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic dd_auto = 1'b0, dd_man = 1'b0, sd_auto = 1'b0, sd_man = 1'b0, vd_auto = 1'b0;
    assign bus.dist_done = dd_auto | dd_man;
    assign bus.sort_done = sd_auto | sd_man;
    assign bus.vote_done = vd_auto;
    bit en_dist = 1'b1;
    bit en_sort = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] q_obs[$];
    logic [63:0] q_exp[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ev(input int kind, input int a, input int b, input int c);
        return {16'(kind), 16'(a), 16'(b), 16'(c)};
    endfunction

    function automatic logic [63:0] outs_word();
        return 64'({bus.test_ren, bus.test_raddr, bus.sample_ren, bus.sample_group, bus.feature_idx,
                    bus.lane_valid, bus.dist_start, bus.dist_metric, bus.sort_clear, bus.sort_start,
                    bus.label_ren, bus.label_raddr, bus.vote_start, bus.query_idx, bus.query_done,
                    bus.batch_done, bus.busy, bus.error, bus.err_code});
    endfunction

    function automatic logic [63:0] activity_word();
        return 64'({bus.test_ren, bus.sample_ren, bus.lane_valid, bus.dist_start, bus.sort_clear,
                    bus.sort_start, bus.label_ren, bus.vote_start, bus.query_done, bus.batch_done, bus.busy});
    endfunction

    // observed transaction stream, one record per enable or pulse
    always @(negedge clk) begin
        if (bus.sort_clear) q_obs.push_back(ev(1, int'(bus.query_idx), 0, 0));
        if (bus.test_ren)   q_obs.push_back(ev(2, int'(bus.test_raddr), 0, 0));
        if (bus.sample_ren) q_obs.push_back(ev(3, int'(bus.sample_group), int'(bus.feature_idx), int'(bus.lane_valid)));
        if (bus.dist_start) q_obs.push_back(ev(4, int'(bus.sample_group), int'(bus.dist_metric), 0));
        if (bus.sort_start) q_obs.push_back(ev(5, 0, 0, 0));
        if (bus.label_ren)  q_obs.push_back(ev(6, int'(bus.label_raddr), 0, 0));
        if (bus.vote_start) q_obs.push_back(ev(7, 0, 0, 0));
        if (bus.query_done) q_obs.push_back(ev(8, int'(bus.query_idx), 0, 0));
        if (bus.batch_done) q_obs.push_back(ev(9, 0, 0, 0));
    end

    // datapath stand-ins: answer each start pulse after 0..3 extra cycles
    initial forever begin
        @(negedge clk);
        if (bus.dist_start && en_dist) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 dd_auto = 1'b1;
            @(posedge clk); #1 dd_auto = 1'b0;
        end
    end
    initial forever begin
        @(negedge clk);
        if (bus.sort_start && en_sort) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 sd_auto = 1'b1;
            @(posedge clk); #1 sd_auto = 1'b0;
        end
    end
    initial forever begin
        @(negedge clk);
        if (bus.vote_start) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 vd_auto = 1'b1;
            @(posedge clk); #1 vd_auto = 1'b0;
        end
    end

    // reference: the full ordered event stream of one successful batch
    task automatic build_exp(input int k, input int s, input int f, input int q, input int m);
        int g_n;
        int lv;
        q_exp.delete();
        g_n = (s + LANES - 1) / LANES;
        for (int qi = 0; qi < q; qi++) begin
            q_exp.push_back(ev(1, qi, 0, 0));
            for (int fi = 0; fi < f; fi++) q_exp.push_back(ev(2, qi * NUM_FEATURES + fi, 0, 0));
            for (int g = 0; g < g_n; g++) begin
                lv = 0;
                for (int i = 0; i < LANES; i++) if (g * LANES + i < s) lv = lv | (1 << i);
                for (int fi = 0; fi < f; fi++) q_exp.push_back(ev(3, g, fi, lv));
                q_exp.push_back(ev(4, g, m, 0));
            end
            q_exp.push_back(ev(5, 0, 0, 0));
            for (int j = 0; j < k; j++) q_exp.push_back(ev(6, j, 0, 0));
            q_exp.push_back(ev(7, 0, 0, 0));
            q_exp.push_back(ev(8, qi, 0, 0));
        end
        q_exp.push_back(ev(9, 0, 0, 0));
    endtask

    task automatic drive_start(input int k, input int s, input int f, input int q, input int m);
        @(posedge clk); #1;
        bus.start            = 1'b1;
        bus.cfg_k            = 4'(k);
        bus.cfg_num_samples  = 12'(s);
        bus.cfg_num_features = 5'(f);
        bus.cfg_num_queries  = 4'(q);
        bus.cfg_metric       = 1'(m);
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic wait_batch_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int cyc = 0; cyc < 20000 && !seen; cyc++) begin
            @(negedge clk);
            if (bus.batch_done) seen = 1'b1;
        end
        if (!seen) chk({tag, "_batch_done_in_budget"}, 64'd0, 64'd1);
    endtask

    task automatic run_batch(input int k, input int s, input int f, input int q, input int m, input bit poke);
        bit seen;
        q_obs.delete();
        build_exp(k, s, f, q, m);
        drive_start(k, s, f, q, m);
        @(negedge clk);
        chk("check_cycle_busy", 64'(bus.busy), 64'd1);
        chk("check_cycle_no_test_ren", 64'(bus.test_ren), 64'd0);
        chk("error_cleared_on_start", 64'(bus.error), 64'd0);
        @(negedge clk);
        chk("first_load_test_ren", 64'(bus.test_ren), 64'd1);
        chk("first_load_sort_clear", 64'(bus.sort_clear), 64'd1);
        seen = 1'b0;
        for (int cyc = 0; cyc < 20000 && !seen; cyc++) begin
            @(negedge clk);
            // a start with a different, illegal config while busy must change nothing
            if (poke && cyc == 4) begin
                bus.start = 1'b1; bus.cfg_k = 4'd0; bus.cfg_num_features = 5'd1;
                bus.cfg_num_queries = 4'd5; bus.cfg_metric = ~bus.cfg_metric;
            end
            if (poke && cyc == 5) bus.start = 1'b0;
            if (bus.batch_done) begin
                seen = 1'b1;
                chk("busy_low_on_batch_done", 64'(bus.busy), 64'd0);
            end
        end
        if (!seen) chk("batch_done_in_budget", 64'd0, 64'd1);
        @(negedge clk);
        chk("event_count", 64'(q_obs.size()), 64'(q_exp.size()));
        for (int i = 0; i < q_exp.size() && i < q_obs.size(); i++)
            chk($sformatf("event%0d", i), q_obs[i], q_exp[i]);
    endtask

    task automatic run_bad(input int k, input int s, input int f, input int q, input string tag);
        q_obs.delete();
        drive_start(k, s, f, q, 0);
        @(negedge clk);
        chk({tag, "_check_busy"}, 64'(bus.busy), 64'd1);
        chk({tag, "_check_error_clear"}, 64'(bus.error), 64'd0);
        @(negedge clk);
        chk({tag, "_error"}, 64'(bus.error), 64'd1);
        chk({tag, "_err_code"}, 64'(bus.err_code), 64'd1);
        chk({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk({tag, "_no_reads"}, 64'(q_obs.size()), 64'd0);
    endtask

    task automatic wait_sort_start(input string tag);
        int cyc;
        for (cyc = 0; cyc < 500 && !bus.sort_start; cyc++) @(negedge clk);
        if (!bus.sort_start) chk({tag, "_sort_start_seen"}, 64'd0, 64'd1);
    endtask

    int bad_k[8] = '{0, 11, 3, 3, 3, 3, 3, 3};
    int bad_s[8] = '{10, 10, 0, 300, 10, 10, 10, 10};
    int bad_f[8] = '{4, 4, 4, 4, 0, 17, 4, 4};
    int bad_q[8] = '{1, 1, 1, 1, 1, 1, 0, 9};

    initial begin
        int n;
        int s, k, f, q, m;
        bit prev_busy;
        bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_k = '0; bus.cfg_num_samples = '0;
        bus.cfg_num_features = '0; bus.cfg_num_queries = '0; bus.cfg_metric = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", outs_word(), 64'd0);

        // directed: single query L2 with partial last lane group, plus start-while-busy
        run_batch(3, 10, 4, 1, 1, 1'b1);
        // directed: three queries, test address stride per query
        run_batch(3, 10, 2, 3, 0, 1'b0);

        // configuration errors, then a valid batch clears the error
        for (int i = 0; i < 8; i++) run_bad(bad_k[i], bad_s[i], bad_f[i], bad_q[i], $sformatf("badcfg%0d", i));
        run_batch(2, 5, 3, 1, 0, 1'b0);

        // sort_done withheld: ERR after exactly TIMEOUT wait cycles
        en_sort = 1'b0;
        drive_start(1, 4, 1, 1, 0);
        wait_sort_start("tmo");
        n = 0;
        prev_busy = 1'b1;
        while (!bus.error && n < 2 * TIMEOUT) begin
            prev_busy = bus.busy;
            @(negedge clk);
            n++;
        end
        chk("tmo_wait_cycles", 64'(n), 64'(TIMEOUT));
        chk("tmo_busy_before_err", 64'(prev_busy), 64'd1);
        chk("tmo_err_code", 64'(bus.err_code), 64'd2);
        chk("tmo_busy_low", 64'(bus.busy), 64'd0);
        // sort_done on the terminal wait cycle wins over the timeout
        drive_start(1, 4, 1, 1, 0);
        wait_sort_start("tmo_edge");
        repeat (TIMEOUT - 1) @(posedge clk);
        #1 sd_man = 1'b1;
        @(posedge clk); #1 sd_man = 1'b0;
        @(negedge clk);
        chk("tmo_edge_label_ren", 64'(bus.label_ren), 64'd1);
        chk("tmo_edge_no_error", 64'(bus.error), 64'd0);
        wait_batch_done("tmo_edge");
        en_sort = 1'b1;

        // abort together with dist_done
        en_dist = 1'b0;
        drive_start(2, 8, 2, 1, 1);
        for (int cyc = 0; cyc < 200 && !bus.dist_start; cyc++) @(negedge clk);
        chk("abort_dist_start_seen", 64'(bus.dist_start), 64'd1);
        @(posedge clk); #1 bus.abort = 1'b1; dd_man = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0; dd_man = 1'b0;
        @(negedge clk);
        chk("abort_quiet", activity_word(), 64'd0);
        chk("abort_error_unchanged", 64'(bus.error), 64'd0);
        q_obs.delete();
        repeat (20) @(negedge clk);
        chk("abort_no_events", 64'(q_obs.size()), 64'd0);
        en_dist = 1'b1;

        // reset in the middle of FETCH
        drive_start(2, 8, 8, 1, 1);
        for (int cyc = 0; cyc < 200 && !bus.sample_ren; cyc++) @(negedge clk);
        chk("rst_fetch_seen", 64'(bus.sample_ren), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", outs_word(), 64'd0);
        run_batch(2, 8, 8, 1, 0, 1'b0);

        // largest legal batch
        run_batch(MAX_K, NUM_SAMPLES, NUM_FEATURES, MAX_QUERIES, 1, 1'b0);

        // randomized legal batches
        for (int t = 0; t < 12; t++) begin
            s = $urandom_range(1, 40);
            k = $urandom_range(1, (s < MAX_K) ? s : MAX_K);
            f = $urandom_range(1, NUM_FEATURES);
            q = $urandom_range(1, MAX_QUERIES);
            m = $urandom_range(0, 1);
            run_batch(k, s, f, q, m, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
